maxpool_2x2_stream: RTL and testbench

//  Streaming 2x2 / stride-2 max-pool on the 32-bit IEEE-754 single-precision pixel stream

---
 rtl/maxpool_2x2_stream.sv | 115 +++++++++++
 tb/tb_maxpool_2x2_stream.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/maxpool_2x2_stream.sv
// Streaming 2x2 / stride-2 max-pool over IEEE-754 single-precision pixels.
// Horizontal pair maxima of even rows are kept in a half-width row buffer.
module maxpool_2x2_stream #(
  parameter int IN_W = 4,
  parameter int IN_H = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  input  logic        in_sof,
  output logic        out_valid,
  output logic [31:0] out_data,
  output logic        out_sof
);

  localparam int DEPTH = IN_W / 2;
  localparam int CW    = (IN_W > 2) ? $clog2(IN_W) : 1;
  localparam int RW    = (IN_H > 2) ? $clog2(IN_H) : 1;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(IN_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IN_H - 1);

  if ((IN_W < 2) || ((IN_W % 2) != 0) || (IN_H < 2) || ((IN_H % 2) != 0)) begin : g_cfg_err
    $error("maxpool_2x2_stream: IN_W and IN_H must be even and >= 2");
  end

  // Sign-magnitude max; operand a is the earlier one in raster order and wins ties.
  function automatic logic [31:0] fp_max(input logic [31:0] a, input logic [31:0] b);
    logic b_wins;
    b_wins = 1'b0;
    if ((a[30:0] == '0) && (b[30:0] == '0))
      b_wins = 1'b0;
    else if (!a[31] && !b[31])
      b_wins = (b[30:0] > a[30:0]);
    else if (a[31] && b[31])
      b_wins = (b[30:0] < a[30:0]);
    else
      b_wins = a[31];
    return b_wins ? b : a;
  endfunction

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [31:0]   hold;
  logic          sof_pending;
  logic [31:0]   rowbuf [DEPTH];

  logic [CW-1:0] eff_col;
  logic [RW-1:0] eff_row;
  logic [AW-1:0] rb_idx;
  logic          at_origin;
  logic          odd_col;
  logic          odd_row;
  logic [31:0]   h_max;
  logic [31:0]   win_max;

  // in_sof forces the beat to (0,0); stale hold/rowbuf data is then overwritten
  // before it can be read, which discards any partial window.
  always_comb begin
    eff_col   = in_sof ? '0 : col;
    eff_row   = in_sof ? '0 : row;
    rb_idx    = AW'(eff_col >> 1);
    at_origin = (eff_col == '0) && (eff_row == '0);
    odd_col   = eff_col[0];
    odd_row   = eff_row[0];
    h_max     = fp_max(hold, in_data);
    win_max   = fp_max(rowbuf[rb_idx], h_max);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      col         <= '0;
      row         <= '0;
      hold        <= '0;
      sof_pending <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_sof     <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      if (in_valid) begin
        if (eff_col == COL_LAST) begin
          col <= '0;
          row <= (eff_row == ROW_LAST) ? '0 : eff_row + RW'(1);
        end else begin
          col <= eff_col + CW'(1);
          row <= eff_row;
        end

        if (!odd_col)
          hold <= in_data;

        if (at_origin)
          sof_pending <= 1'b1;
        else if (odd_col && odd_row)
          sof_pending <= 1'b0;

        if (odd_col && odd_row) begin
          out_valid <= 1'b1;
          out_data  <= win_max;
          out_sof   <= sof_pending;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst && in_valid && odd_col && !odd_row)
      rowbuf[rb_idx] <= h_max;
  end

endmodule

// File: tb/tb_maxpool_2x2_stream.sv
// Directed bench for maxpool_2x2_stream: expected windows are queued when the
// bottom-right beat is driven and checked (value, sof, cycle) when out_valid fires.
module tb_maxpool_2x2_stream;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_sof;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_sof;

  maxpool_2x2_stream #(.IN_W(4), .IN_H(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_sof    (in_sof),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sof   (out_sof)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        sof;
    int unsigned due;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned ncyc   = 0;

  logic [31:0] ramp    [16];
  logic [31:0] ramp_ex [4];
  logic [31:0] neg_px  [16];
  logic [31:0] neg_ex  [4];

  always @(negedge clk) begin
    exp_t e;
    ncyc++;
    if (out_valid === 1'b1) begin
      checks++;
      assert (sb.size() != 0)
      else begin
        errors++;
        $error("FAIL unexpected_out observed=%h expected=no_output", out_data);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        checks++;
        assert (out_data === e.data)
        else begin
          errors++;
          $error("FAIL out_data observed=%h expected=%h", out_data, e.data);
        end
        checks++;
        assert (out_sof === e.sof)
        else begin
          errors++;
          $error("FAIL out_sof observed=%b expected=%b (data %h)", out_sof, e.sof, e.data);
        end
        checks++;
        assert (ncyc === e.due)
        else begin
          errors++;
          $error("FAIL latency observed_cycle=%0d expected_cycle=%0d", ncyc, e.due);
        end
      end
    end else if (sb.size() != 0 && ncyc >= sb[0].due) begin
      e = sb.pop_front();
      checks++;
      assert (out_valid === 1'b1)
      else begin
        errors++;
        $error("FAIL missing_out observed_valid=%b expected=%h", out_valid, e.data);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1; the beat is sampled at the next posedge and its result
  // must be visible at the negedge that follows.
  task automatic send(input logic [31:0] d, input logic sof,
                      input logic exp_v, input logic [31:0] exp_d, input logic exp_s);
    exp_t e;
    in_valid = 1'b1;
    in_data  = d;
    in_sof   = sof;
    if (exp_v) begin
      e.data = exp_d;
      e.sof  = exp_s;
      e.due  = ncyc + 2;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_data  = '0;
  endtask

  task automatic send_frame(input logic [31:0] px[16], input logic [31:0] ex[4],
                            input logic sof0, input int n, input int gap_max);
    for (int i = 0; i < n; i++) begin
      logic br;
      int   ridx;
      br   = ((i / 4) % 2 == 1) && (i % 2 == 1);
      ridx = (i / 8) * 2 + (i % 4) / 2;
      send(px[i], (i == 0) ? sof0 : 1'b0, br, br ? ex[ridx] : 32'h0, (ridx == 0));
      if (gap_max > 0) begin
        repeat ($urandom_range(0, gap_max)) begin
          @(posedge clk);
          #1;
        end
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("reset_out_valid", {31'b0, out_valid}, 32'h0);
    chk("reset_out_data", out_data, 32'h0);
    chk("reset_out_sof", {31'b0, out_sof}, 32'h0);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ramp = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
             32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000,
             32'h41100000, 32'h41200000, 32'h41300000, 32'h41400000,
             32'h41500000, 32'h41600000, 32'h41700000, 32'h41800000};
    ramp_ex = '{32'h40C00000, 32'h41000000, 32'h41600000, 32'h41800000};
    // Windows: {-1,-2;-0.5,-3} {-0,+0;-1,-2} {-1,+0.5;-2,-3} {+0,-0;-1,-0}
    neg_px = '{32'hBF800000, 32'hC0000000, 32'h80000000, 32'h00000000,
               32'hBF000000, 32'hC0400000, 32'hBF800000, 32'hC0000000,
               32'hBF800000, 32'h3F000000, 32'h00000000, 32'h80000000,
               32'hC0000000, 32'hC0400000, 32'hBF800000, 32'h80000000};
    neg_ex = '{32'hBF000000, 32'h80000000, 32'h3F000000, 32'h00000000};

    rst      = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_sof   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // 1) ramp frame, back to back
    send_frame(ramp, ramp_ex, 1'b1, 16, 0);
    // 2) negative / signed-zero windows
    send_frame(neg_px, neg_ex, 1'b1, 16, 0);
    // 3) ramp with random bubbles
    send_frame(ramp, ramp_ex, 1'b1, 16, 3);
    // 4) in_sof on beat 7 restarts the frame
    send_frame(ramp, ramp_ex, 1'b1, 6, 0);
    send_frame(ramp, ramp_ex, 1'b1, 16, 0);
    // 5) reset after beat 10, then a frame without in_sof
    send_frame(ramp, ramp_ex, 1'b1, 10, 0);
    do_reset();
    send_frame(ramp, ramp_ex, 1'b0, 16, 0);
    // 6) two frames back to back, second without in_sof
    send_frame(ramp, ramp_ex, 1'b1, 16, 0);
    send_frame(ramp, ramp_ex, 1'b0, 16, 0);

    repeat (6) @(posedge clk);
    checks++;
    assert (sb.size() == 0)
    else begin
      errors++;
      $error("FAIL drain observed=%0d pending expected=0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
